// File: rtl/gpr_file_pkg.sv
// Shared types and helpers for the multi-port GPR file.
// Optional parity storage is enabled with GPR_FILE_PARITY_EN.
package gpr_file_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int PAR_MAX_W = 1024;

   function automatic int clog2_addr(input int depth);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) < depth) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

   // Callers zero-extend narrower words, which leaves the XOR unchanged.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/gpr_wr_arbiter.sv
// Bypass resolver for one read port: finds the winning same-edge write to
// the read address (highest enabled write port wins).
module gpr_wr_arbiter
   import gpr_file_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int AW       = 5,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [AW-1:0]            rd_addr,
   output logic                     hit,
   output logic [DATA_W-1:0]        data
);

   logic zero_blocked;

   assign zero_blocked = (ZERO_REG != 0) && (rd_addr == '0);

   // Ascending scan: a later (higher-index) match overrides an earlier one.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr) && !zero_blocked) begin
            hit  = 1'b1;
            data = wr_data[p*DATA_W +: DATA_W];
         end else begin
            hit  = hit;
            data = data;
         end
      end
   end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file with write-first bypass and a post-reset clear sweep.
// Define GPR_FILE_PARITY_EN to add a per-entry even-parity bit and parity_err.
module gpr_file_mp
   import gpr_file_pkg::*;
#(
   parameter  int DATA_W   = 32,
   parameter  int DEPTH    = 32,
   parameter  int NUM_RD   = 2,
   parameter  int NUM_WR   = 1,
   parameter  int ZERO_REG = 1,
   localparam int AW       = clog2_addr(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic                     ready
`ifdef GPR_FILE_PARITY_EN
   ,
   output logic [NUM_RD-1:0]        parity_err
`endif
);

`ifdef GPR_FILE_PARITY_EN
   localparam int EW = DATA_W + 1;
`else
   localparam int EW = DATA_W;
`endif

   state_t                     state;
   logic [AW-1:0]              clr_ptr;
   logic [EW-1:0]              mem [DEPTH];
   logic [NUM_RD-1:0]          byp_hit;
   logic [NUM_RD*DATA_W-1:0]   byp_data;

   function automatic logic [EW-1:0] make_entry(input logic [DATA_W-1:0] d);
`ifdef GPR_FILE_PARITY_EN
      return {even_parity(PAR_MAX_W'(d)), d};
`else
      return d;
`endif
   endfunction

   for (genvar r = 0; r < NUM_RD; r++) begin : g_byp
      gpr_wr_arbiter #(
         .DATA_W   (DATA_W),
         .AW       (AW),
         .NUM_WR   (NUM_WR),
         .ZERO_REG (ZERO_REG)
      ) u_arb (
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .rd_addr (rd_addr[r*AW +: AW]),
         .hit     (byp_hit[r]),
         .data    (byp_data[r*DATA_W +: DATA_W])
      );
   end

   // Storage has no reset so it can map onto RAM; the sweep clears it instead.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
         end else begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (wr_en[p] && !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0))) begin
                  mem[wr_addr[p*AW +: AW]] <= make_entry(wr_data[p*DATA_W +: DATA_W]);
               end
            end
         end
      end
   end

   // Sweep/run control.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_ptr <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr_ptr <= clr_ptr + AW'(1);
               if (clr_ptr == AW'(DEPTH - 1)) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               ready <= 1'b1;
            end
            default: begin
               state   <= CLEAR;
               clr_ptr <= '0;
               ready   <= 1'b0;
            end
         endcase
      end
   end

   // Registered read ports: zero register, then bypass, then storage.
   always_ff @(posedge clk) begin
      if (reset || (state != RUN)) begin
         rd_data <= '0;
`ifdef GPR_FILE_PARITY_EN
         parity_err <= '0;
`endif
      end else begin
         for (int r = 0; r < NUM_RD; r++) begin
            if ((ZERO_REG != 0) && (rd_addr[r*AW +: AW] == '0)) begin
               rd_data[r*DATA_W +: DATA_W] <= '0;
`ifdef GPR_FILE_PARITY_EN
               parity_err[r] <= 1'b0;
`endif
            end else if (byp_hit[r]) begin
               rd_data[r*DATA_W +: DATA_W] <= byp_data[r*DATA_W +: DATA_W];
`ifdef GPR_FILE_PARITY_EN
               parity_err[r] <= 1'b0;
`endif
            end else begin
               rd_data[r*DATA_W +: DATA_W] <= mem[rd_addr[r*AW +: AW]][DATA_W-1:0];
`ifdef GPR_FILE_PARITY_EN
               parity_err[r] <= ^mem[rd_addr[r*AW +: AW]];
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Scoreboard bench for gpr_file_mp (DEPTH 32, two read and two write ports).
module tb_gpr_file_mp;

   localparam int DW = 32;
   localparam int DEPTH = 32;
   localparam int AW = 5;

   logic          clk;
   logic          reset;
   logic [1:0]    wr_en;
   logic [2*AW-1:0] wr_addr;
   logic [2*DW-1:0] wr_data;
   logic [2*AW-1:0] rd_addr;
   logic [2*DW-1:0] rd_data;
   logic          ready;
`ifdef GPR_FILE_PARITY_EN
   logic [1:0]    parity_err;
`endif

   gpr_file_mp #(
      .DATA_W   (DW),
      .DEPTH    (DEPTH),
      .NUM_RD   (2),
      .NUM_WR   (2),
      .ZERO_REG (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .ready   (ready)
`ifdef GPR_FILE_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string             nm;
      logic [1:0][DW-1:0] rd;
      logic              rdy;
   } exp_t;

   exp_t        sbq[$];
   logic [DW-1:0] model [DEPTH];
   logic        m_run;
   int          m_cnt;
   int          checks;
   int          errors;

   // One clock: push expectation from the model, step the DUT, pop and compare.
   task automatic drive(input logic rst, input logic [1:0] we,
                        input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                        input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                        input string nm);
      exp_t e;
      logic [AW-1:0] ra [2];
      logic [DW-1:0] v;
      reset   = rst;
      wr_en   = we;
      wr_addr = {wa1, wa0};
      wr_data = {wd1, wd0};
      rd_addr = {ra1, ra0};
      ra[0] = ra0;
      ra[1] = ra1;
      e.nm = nm;
      for (int r = 0; r < 2; r++) begin
         v = 32'd0;
         if (!rst && m_run && ra[r] != 5'd0) begin
            v = model[ra[r]];
            if (we[0] && wa0 == ra[r]) v = wd0;
            if (we[1] && wa1 == ra[r]) v = wd1;
         end
         e.rd[r] = v;
      end
      if (rst) begin
         m_run = 1'b0;
         m_cnt = 0;
      end else if (!m_run) begin
         m_cnt++;
         if (m_cnt == DEPTH) begin
            m_run = 1'b1;
            for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
         end
      end else begin
         if (we[0] && wa0 != 5'd0) model[wa0] = wd0;
         if (we[1] && wa1 != 5'd0) model[wa1] = wd1;
      end
      e.rdy = m_run;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      checks++;
      if (ready !== e.rdy) begin
         errors++;
         $display("FAIL %s ready: got %0b expected %0b", e.nm, ready, e.rdy);
      end
      for (int r = 0; r < 2; r++) begin
         checks++;
         if (rd_data[r*DW +: DW] !== e.rd[r]) begin
            errors++;
            $display("FAIL %s rd_data[%0d]: got %h expected %h", e.nm, r, rd_data[r*DW +: DW], e.rd[r]);
         end
      end
`ifdef GPR_FILE_PARITY_EN
      checks++;
      if (parity_err !== 2'b00) begin
         errors++;
         $display("FAIL %s parity_err: got %b expected 00", e.nm, parity_err);
      end
`endif
   endtask

   task automatic idle_read(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input string nm);
      drive(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, ra0, ra1, nm);
   endtask

   // Writes during the sweep must be ignored; addr 5 is cleared early on.
   task automatic do_sweep(input int cycles, input string nm);
      for (int i = 0; i < cycles; i++) begin
         drive(1'b0, 2'b01, 5'd5, 5'd6, 32'hBAD0_0000 + 32'(i), 32'h0, 5'd5, 5'd6, nm);
      end
   endtask

   task automatic test_reset;
      drive(1'b1, 2'b11, 5'd3, 5'd4, 32'h1111_1111, 32'h2222_2222, 5'd3, 5'd4, "reset0");
      drive(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd4, "reset1");
   endtask

   task automatic test_sweep;
      do_sweep(DEPTH, "sweep");
      idle_read(5'd5, 5'd6, "post_sweep_rd5");
   endtask

   task automatic test_write_read;
      idle_read(5'd7, 5'd7, "rd7_before");
      drive(1'b0, 2'b01, 5'd7, 5'd0, 32'hDEAD_BEEF, 32'd0, 5'd8, 5'd8, "wr7");
      idle_read(5'd7, 5'd7, "rd7_after");
      for (int i = 10; i < 20; i++) begin
         drive(1'b0, 2'b11, 5'(i), 5'(i + 10), $urandom, $urandom, 5'd7, 5'(i - 1), "wr_loop");
      end
      for (int i = 10; i < 30; i += 2) begin
         idle_read(5'(i), 5'(i + 1), "rd_loop");
      end
   endtask

   task automatic test_bypass;
      drive(1'b0, 2'b01, 5'd9, 5'd0, 32'h1234_5678, 32'd0, 5'd7, 5'd9, "bypass_p0");
      drive(1'b0, 2'b10, 5'd0, 5'd11, 32'd0, 32'hCAFE_F00D, 5'd11, 5'd9, "bypass_p1");
      idle_read(5'd9, 5'd11, "bypass_after");
   endtask

   task automatic test_zero;
      drive(1'b0, 2'b11, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0, "zero_bypass");
      idle_read(5'd0, 5'd0, "zero_read");
   endtask

   task automatic test_conflict;
      drive(1'b0, 2'b11, 5'd3, 5'd3, 32'h0000_AAAA, 32'h0000_5555, 5'd3, 5'd2, "conflict_byp");
      idle_read(5'd3, 5'd3, "conflict_rd");
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 2'b01, 5'd14, 5'd0, 32'h5000_0000 + 32'(i), 32'd0, 5'd14, 5'd14, "b2b");
      end
      idle_read(5'd14, 5'd13, "b2b_final");
   endtask

   task automatic test_reset_mid;
      drive(1'b1, 2'b01, 5'd7, 5'd0, 32'h7777_7777, 32'd0, 5'd7, 5'd7, "rst_run");
      do_sweep(10, "sweep_a");
      drive(1'b1, 2'b01, 5'd7, 5'd0, 32'h8888_8888, 32'd0, 5'd7, 5'd9, "rst_mid");
      do_sweep(DEPTH, "sweep_b");
      idle_read(5'd7, 5'd9, "after_resweep");
      drive(1'b0, 2'b01, 5'd7, 5'd0, 32'h0BAD_CAFE, 32'd0, 5'd12, 5'd7, "run_again");
      idle_read(5'd7, 5'd3, "run_again_rd");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_run  = 1'b0;
      m_cnt  = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
      reset   = 1'b1;
      wr_en   = 2'b00;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      test_reset();
      test_sweep();
      test_write_read();
      test_bypass();
      test_zero();
      test_conflict();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpr_file_mp.md
Name: gpr_file_mp

Overview:
Parametrised multi-port general-purpose register file. It is the next-generation successor to the single-write, two-read GPR file used by the single-cycle core.
- Configurable data width, register count, read-port count and write-port count.
- Write-first bypass, deterministic write-port priority and an optional hardwired zero register.
- After reset it runs a sequential clear sweep, so the storage can map to RAM without a one-cycle array reset.
- Sits between decode (register addresses) and writeback (result buses) in the datapath.

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers; power of two, >= 2
NUM_RD, 2, read ports, 1..4
NUM_WR, 1, write ports, 1..2
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses, port p at bits [p*AW +: AW], AW = clog2(DEPTH)
wr_data  in  NUM_WR*DATA_W  write data, port p at [p*DATA_W +: DATA_W]
rd_addr  in  NUM_RD*AW  read addresses
rd_data  out  NUM_RD*DATA_W  registered read data
ready  out  1  high when the clear sweep is done and the file accepts accesses

Behaviour:
- Reset (sampled at clk edge):
  - rd_data <= 0, ready <= 0, state <= CLEAR, clr_ptr <= 0.
  - Storage is not touched in the reset cycle.
  - While reset stays high, remain in CLEAR with clr_ptr = 0.
- FSM states CLEAR and RUN:
  - CLEAR: each cycle with reset low, mem[clr_ptr] <= 0 and clr_ptr increments.
  - When clr_ptr == DEPTH-1 is cleared, go to RUN next edge and ready <= 1.
  - Sweep takes exactly DEPTH cycles after reset deasserts.
- In CLEAR:
  - wr_en is ignored; no write port reaches storage.
  - rd_data <= 0 every cycle.
- In RUN, writes:
  - For each p with wr_en[p], mem[wr_addr[p]] <= wr_data[p].
  - With ZERO_REG = 1, writes to address 0 are dropped.
- In RUN, reads:
  - rd_data[r] <= value at rd_addr[r]; latency 1 cycle.
  - Write-first bypass: if a same-edge enabled write targets rd_addr[r] (and the address is not 0 with ZERO_REG), rd_data[r] gets that write's wr_data, not the stale storage value.
- Same-address writes: if two write ports hit one address on the same edge, the higher-index port wins for both storage and bypass.
- ZERO_REG = 1: any rd_addr == 0 yields 0, regardless of writes.
- Reset mid-operation (including mid-sweep) aborts immediately: ready drops the next edge and the sweep restarts from 0.
- Simultaneous reset and wr_en: reset wins; no write.
- Addresses are unsigned. There is no out-of-range case because DEPTH is a power of two.

Optional Feature:
- Macro GPR_FILE_PARITY_EN.
- When defined:
  - Each entry stores one extra even-parity bit computed from write data.
  - Reads recompute parity. Port parity_err out NUM_RD is registered alongside rd_data; bit r is high for one cycle when a read of port r mismatches.
  - Bypassed reads never flag. Register 0 under ZERO_REG never flags. Reset clears parity_err.
  - The sweep writes parity 0.
- When undefined: no extra storage bit and no parity_err port.

Decomposition:
- Package gpr_file_pkg:
  - state enum typedef (CLEAR, RUN).
  - function clog2_addr.
  - function even_parity(DATA_W).
- One natural sub-module, gpr_wr_arbiter: resolves per-address write priority and produces the bypass match/data for each read port. Instantiated NUM_RD times for bypass.

Test Plan:
- Reset then DEPTH=32 sweep: reset high 2 cycles, low 32 cycles -> ready 0 through cycle 31, 1 at cycle 32; rd_addr=5 afterwards -> rd_data 0.
- Write/read latency: write addr 7 = 0xDEADBEEF at edge N, read addr 7 at N+1 -> rd_data 0xDEADBEEF after edge N+1; prior value unaffected before the write edge.
- Bypass: same cycle wr_en=1, wr_addr=9, wr_data=0x12345678, rd_addr[1]=9 -> rd_data[1] = 0x12345678 after that edge.
- Zero register: write 0xFFFFFFFF to addr 0, then read addr 0 on both ports, including a same-cycle bypass attempt -> 0 each time.
- Write conflict, NUM_WR=2: port0 writes 3 <= 0xAAAA, port1 writes 3 <= 0x5555 same edge -> later read of addr 3 returns 0x5555.
- Reset mid-sweep and during writes: assert reset at sweep cycle 10 -> ready stays 0, sweep restarts, 32 further cycles to ready; an enabled write in the reset cycle leaves storage unchanged.
